// File: rtl/up5bit_chk_pkg.sv
// Shared types and sizing helpers for the
// count-stream checker.
package up5bit_chk_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int LOCK_CNT_DEF = 4;
  localparam int LOCK_CNT_MAX = 15;
  localparam int RUN_W_DEF    = $clog2(LOCK_CNT_DEF + 1);

  function automatic int run_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/up5bit_count_checker_if.sv
// Monitored count bus: sampled value plus
// qualifier, driven by the counter side.
interface up5bit_count_checker_if #(
  parameter int WIDTH = 5
);

  logic [WIDTH-1:0] count_in;
  logic             count_valid;

  modport master (
    output count_in,
    output count_valid
  );

  modport slave (
    input count_in,
    input count_valid
  );

endinterface

// File: rtl/up5bit_sat_counter.sv
// Saturating up-counter; increment beats clear
// so a same-cycle event lands as a count of 1.
module up5bit_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      if (clr_i) begin
        cnt_d = W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/up5bit_count_checker.sv
// Lock-and-track monitor for a free-running
// up-counter bus; flags step errors and restarts.
module up5bit_count_checker
  import up5bit_chk_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  up5bit_count_checker_if.slave cnt_if,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic                 err_pulse,
  output logic                 restart,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int RW = run_w(LOCK_CNT);

  chk_state_t       state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic [RW-1:0]    run_inc;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             error_q, error_d;
  logic             pulse_q, pulse_d;
  logic             rstrt_q, rstrt_d;
  logic             match;

  assign match   = (cnt_if.count_in == exp_q);
  assign run_inc = run_q + 1'b1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    exp_d   = exp_q;
    pulse_d = 1'b0;
    rstrt_d = 1'b0;
    if (cnt_if.count_valid) begin
      exp_d = cnt_if.count_in + 1'b1;
      unique case (state_q)
        HUNT: begin
          state_d = SYNC;
          run_d   = '0;
        end
        SYNC: begin
          if (!match) begin
            run_d = '0;
          end else if (run_inc == RW'(LOCK_CNT)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d = SYNC;
            run_d   = '0;
            // A jump back to zero is a source restart, not a fault
            if (cnt_if.count_in == '0) begin
              rstrt_d = 1'b1;
            end else begin
              pulse_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    error_d = error_q;
    if (pulse_d) begin
      error_d = 1'b1;
    end else if (clear) begin
      error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
      run_q   <= '0;
      exp_q   <= '0;
      error_q <= 1'b0;
      pulse_q <= 1'b0;
      rstrt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      exp_q   <= exp_d;
      error_q <= error_d;
      pulse_q <= pulse_d;
      rstrt_q <= rstrt_d;
    end
  end

  up5bit_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (clear),
    .inc_i (pulse_d),
    .cnt_o (err_count)
  );

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign err_pulse = pulse_q;
  assign restart   = rstrt_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_up5bit_count_checker.sv
// Scoreboard bench: directed scenarios then random
// stream, two DUTs differing only in ERR_CNT_W.
module tb_up5bit_count_checker;

  typedef struct {
    logic       locked;
    logic       error;
    logic       pulse;
    logic       restart;
    logic [7:0] ec8;
    logic [1:0] ec2;
    logic [4:0] expv;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       lk_a, er_a, ep_a, rs_a;
  logic       lk_b, er_b, ep_b, rs_b;
  logic [7:0] ec_a;
  logic [1:0] ec_b;
  logic [4:0] ex_a, ex_b;

  int n_vec;
  int n_bad;
  exp_t sbq[$];

  up5bit_count_checker_if #(.WIDTH(5)) cif ();

  up5bit_count_checker #(
    .WIDTH(5), .LOCK_CNT(4), .ERR_CNT_W(8)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .cnt_if(cif.slave),
    .clear(clear), .locked(lk_a), .error(er_a),
    .err_pulse(ep_a), .restart(rs_a),
    .err_count(ec_a), .expected(ex_a)
  );

  up5bit_count_checker #(
    .WIDTH(5), .LOCK_CNT(4), .ERR_CNT_W(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cnt_if(cif.slave),
    .clear(clear), .locked(lk_b), .error(er_b),
    .err_pulse(ep_b), .restart(rs_b),
    .err_count(ec_b), .expected(ex_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit m_seen;
  bit m_lock;
  int m_good;
  int m_exp;
  bit m_err;
  int m_ecnt;
  int nxt;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, want, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("locked",    32'(lk_a), 32'(e.locked));
      check("error",     32'(er_a), 32'(e.error));
      check("err_pulse", 32'(ep_a), 32'(e.pulse));
      check("restart",   32'(rs_a), 32'(e.restart));
      check("err_count", 32'(ec_a), 32'(e.ec8));
      check("expected",  32'(ex_a), 32'(e.expv));
      check("err_cnt_w2", 32'(ec_b), 32'(e.ec2));
      check("locked_w2", 32'(lk_b), 32'(e.locked));
      check("error_w2",  32'(er_b), 32'(e.error));
    end
  end

  task automatic step(input logic rst, input logic v,
                      input int c, input logic clr);
    exp_t e;
    bit ep;
    bit rs;
    @(negedge clk);
    reset_n         = rst;
    cif.count_valid = v;
    cif.count_in    = 5'(c);
    clear           = clr;
    ep = 0;
    rs = 0;
    c  = c % 32;
    if (!rst) begin
      m_seen = 0; m_lock = 0; m_good = 0;
      m_exp  = 0; m_err  = 0; m_ecnt = 0;
    end else begin
      if (v) begin
        if (!m_seen) begin
          m_seen = 1;
          m_good = 0;
        end else if (m_lock) begin
          if (c != m_exp) begin
            m_lock = 0;
            m_good = 0;
            if (c == 0) rs = 1;
            else        ep = 1;
          end
        end else if (c == m_exp) begin
          m_good++;
          if (m_good == 4) begin
            m_lock = 1;
            m_good = 0;
          end
        end else begin
          m_good = 0;
        end
        m_exp = (c + 1) % 32;
      end
      if (ep) begin
        m_err  = 1;
        m_ecnt = clr ? 1 : m_ecnt + 1;
      end else if (clr) begin
        m_err  = 0;
        m_ecnt = 0;
      end
    end
    e.locked  = m_lock;
    e.error   = m_err;
    e.pulse   = ep;
    e.restart = rs;
    e.ec8     = 8'((m_ecnt > 255) ? 255 : m_ecnt);
    e.ec2     = 2'((m_ecnt > 3) ? 3 : m_ecnt);
    e.expv    = 5'(m_exp);
    sbq.push_back(e);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 1, nxt, 0);
      nxt = (nxt + 1) % 32;
    end
  endtask

  task automatic bad_step(input logic clr);
    int b;
    b = (nxt + 2) % 32;
    if (b == 0) b = 3;
    step(1, 1, b, clr);
    nxt = (b + 1) % 32;
  endtask

  initial begin
    int r;
    int c;
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    clear = 1'b0;
    cif.count_valid = 1'b0;
    cif.count_in = '0;

    step(0, 1, 17, 0);
    step(0, 1, 17, 0);
    nxt = 3;
    feed(5);
    feed(2);
    bad_step(0);
    feed(4);
    while (nxt != 20) feed(1);
    step(1, 1, 0, 0);
    nxt = 1;
    feed(4);
    while (nxt != 30) feed(1);
    feed(4);

    step(0, 0, 0, 0);
    for (int i = 5; i < 10; i++) begin
      step(1, 0, $urandom_range(0, 31), 0);
      step(1, 1, i, 0);
      step(1, 0, $urandom_range(0, 31), 0);
    end
    nxt = 10;
    for (int k = 0; k < 5; k++) begin
      bad_step(0);
      feed(4);
    end
    step(1, 0, 0, 1);
    feed(2);
    bad_step(1);
    feed(4);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       c = $urandom_range(0, 31);
      else if (r < 7)  c = 0;
      else             c = nxt;
      nxt = (c + 1) % 32;
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           c, ($urandom_range(0, 24) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
